sfi_rewrite_ctrl: RTL

Streaming controller for the SFI store-sandboxing datapath. It accepts 64-bit instruction words over a valid/ready stream and decodes the opcode field. Store instructions are rewritten with a configurable AND/OR sandbox mask; all other instructions pass through unchanged. It owns mask configuration, a lock/run/drain state machine that prevents reconfiguration while instructions are in flight, and rewrite/pass statistics. It sits between the instruction fetch stream and the downstream consumer.

---
 rtl/sfi_rewrite_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sfi_rewrite_ctrl.sv
// SFI store-sandboxing rewrite stage: masks store words with (and_mask, or_mask), passes others; 1-cycle latency.
// Backpressure: single output register; in_ready drops when the held word is not taken or outside RUN.
module sfi_rewrite_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [63:0]      cfg_wdata,
    input  logic             cfg_lock,
    input  logic             halt,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             out_rewritten,
    output logic [CNT_W-1:0] store_count,
    output logic [CNT_W-1:0] pass_count,
    output logic [1:0]       state,
    output logic             cfg_err
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [63:0]      r_and_mask;
    logic [63:0]      r_or_mask;
    logic             r_and_wr;
    logic             r_or_wr;
    logic             r_out_valid;
    logic [63:0]      r_out_data;
    logic             r_out_rewritten;
    logic [CNT_W-1:0] r_store_cnt;
    logic [CNT_W-1:0] r_pass_cnt;
    logic             r_cfg_err;

    logic        w_is_store;
    logic [63:0] w_rw_data;
    logic        w_in_hs;
    logic        w_idle;
    logic        w_clr;
    logic        w_wr_and;
    logic        w_wr_or;
    logic        w_flags_ok;
    logic        w_err_set;

    always_comb begin
        w_is_store = 1'b0;
        case (in_data[31:26])
            6'd40, 6'd41, 6'd42, 6'd43, 6'd44,
            6'd45, 6'd46, 6'd56, 6'd60, 6'd63: w_is_store = 1'b1;
            default:                           w_is_store = 1'b0;
        endcase
    end

    assign w_rw_data  = w_is_store ? ((in_data & r_and_mask) | r_or_mask) : in_data;
    assign in_ready   = (r_state == S_RUN) && (!r_out_valid || out_ready);
    assign w_in_hs    = in_valid && in_ready;
    assign w_idle     = (r_state == S_IDLE);
    assign w_clr      = cfg_we && (cfg_addr == 2'd2);
    assign w_wr_and   = cfg_we && w_idle && (cfg_addr == 2'd0);
    assign w_wr_or    = cfg_we && w_idle && (cfg_addr == 2'd1);
    // Lock qualification sees a mask write landing in the same cycle.
    assign w_flags_ok = (r_and_wr || w_wr_and) && (r_or_wr || w_wr_or);
    assign w_err_set  = (cfg_we && !w_idle && !w_clr) ||
                        (w_idle && cfg_lock && !w_flags_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_and_mask <= '0;
            r_or_mask  <= '0;
            r_and_wr   <= 1'b0;
            r_or_wr    <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            if (w_wr_and) begin
                r_and_mask <= cfg_wdata;
                r_and_wr   <= 1'b1;
            end
            if (w_wr_or) begin
                r_or_mask <= cfg_wdata;
                r_or_wr   <= 1'b1;
            end
            if (w_clr)
                r_cfg_err <= 1'b0;
            else if (w_err_set)
                r_cfg_err <= 1'b1;
            case (r_state)
                S_IDLE:  if (cfg_lock && w_flags_ok) r_state <= S_RUN;
                S_RUN:   if (halt) r_state <= S_DRAIN;
                S_DRAIN: if (!r_out_valid) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid     <= 1'b0;
            r_out_data      <= '0;
            r_out_rewritten <= 1'b0;
        end else if (w_in_hs) begin
            r_out_valid     <= 1'b1;
            r_out_data      <= w_rw_data;
            r_out_rewritten <= w_is_store;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Clear takes priority over a same-cycle handshake: that word goes uncounted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_store_cnt <= '0;
            r_pass_cnt  <= '0;
        end else if (w_clr) begin
            r_store_cnt <= '0;
            r_pass_cnt  <= '0;
        end else if (w_in_hs) begin
            if (w_is_store && (r_store_cnt != '1))
                r_store_cnt <= r_store_cnt + CNT_ONE;
            if (!w_is_store && (r_pass_cnt != '1))
                r_pass_cnt <= r_pass_cnt + CNT_ONE;
        end
    end

    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_rewritten = r_out_rewritten;
    assign store_count   = r_store_cnt;
    assign pass_count    = r_pass_cnt;
    assign state         = r_state;
    assign cfg_err       = r_cfg_err;
endmodule
